// File: rtl/mc_core_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, FSM states, ALU controls.
package mc_core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR
  } alu_op_t;

  function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module mc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core sharing one req/ready memory port for instructions and data.
module multi_cycle_core
  import mc_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned LED_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_mode,
  input  logic                  step,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  retire,
  output logic [31:0]           instret,
  output logic                  halted,
  output logic                  illegal,
  output logic [LED_WIDTH-1:0]  leds
);

  state_t      state;
  logic [31:0] pc, ir, a_q, b_q, imm_q, alu_q, mdr;
  alu_op_t     alu_op_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  mc_regfile u_rf (
    .clk(clk), .rst(rst), .we(rf_we), .waddr(ir[11:7]), .wdata(rf_wdata),
    .raddr1(ir[19:15]), .raddr2(ir[24:20]), .rdata1(rf_rdata1), .rdata2(rf_rdata2)
  );

  function automatic logic [LED_WIDTH-1:0] led_fold(input logic [31:0] v);
    led_fold = '0;
    for (int unsigned k = 0; k < 32 / LED_WIDTH; k++)
      led_fold = led_fold | v[k*LED_WIDTH +: LED_WIDTH];
  endfunction

  logic        legal;
  alu_op_t     alu_op_d;
  logic [31:0] imm_d;

  always_comb begin
    legal    = 1'b0;
    alu_op_d = ALU_ADD;
    imm_d    = '0;
    case (opcode)
      OPC_LOAD: begin
        legal = (f3 == 3'b010);
        imm_d = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_STORE: begin
        legal = (f3 == 3'b010);
        imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OPC_BRANCH: begin
        legal    = (f3 == 3'b000) || (f3 == 3'b001);
        alu_op_d = ALU_SUB;
        imm_d    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_OP: begin
        case ({f7, f3})
          10'b0000000_000: begin legal = 1'b1; alu_op_d = ALU_ADD; end
          10'b0100000_000: begin legal = 1'b1; alu_op_d = ALU_SUB; end
          10'b0000000_111: begin legal = 1'b1; alu_op_d = ALU_AND; end
          10'b0000000_110: begin legal = 1'b1; alu_op_d = ALU_OR;  end
          default:         legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = (f3 == 3'b000);
        imm_d = {{20{ir[31]}}, ir[31:20]};
      end
      OPC_JAL: begin
        legal = 1'b1;
        imm_d = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  logic [31:0] opnd_b, alu_d, pc_plus4, target;
  logic        is_ctrl, taken, target_bad;

  assign opnd_b     = ((opcode == OPC_OP) || (opcode == OPC_BRANCH)) ? b_q : imm_q;
  assign alu_d      = alu_calc(alu_op_q, a_q, opnd_b);
  assign pc_plus4   = pc + 32'd4;
  assign target     = pc + imm_q;
  assign is_ctrl    = (opcode == OPC_BRANCH) || (opcode == OPC_JAL);
  assign taken      = (opcode == OPC_JAL) ||
                      ((opcode == OPC_BRANCH) && ((a_q == b_q) ^ f3[0]));
  assign target_bad = taken && (target[1:0] != 2'b00);

  logic        retire_now;
  logic [31:0] next_pc, retire_val;

  always_comb begin
    rf_we      = 1'b0;
    rf_wdata   = alu_q;
    retire_now = 1'b0;
    next_pc    = pc_plus4;
    retire_val = alu_q;
    case (state)
      S_EXECUTE: begin
        if (is_ctrl && !target_bad) begin
          retire_now = 1'b1;
          next_pc    = taken ? target : pc_plus4;
          retire_val = (opcode == OPC_JAL) ? pc_plus4 : alu_d;
          if (opcode == OPC_JAL) begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
          end
        end
      end
      S_MEM: begin
        if (mem_req && mem_ready && (opcode == OPC_STORE)) retire_now = 1'b1;
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_wdata   = (opcode == OPC_LOAD) ? mdr : alu_q;
        retire_now = 1'b1;
        retire_val = rf_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Reset lands in FETCH without a request; the first FETCH cycle then
      // either issues the fetch or parks in IDLE when single-stepping.
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr       <= '0;
      alu_op_q  <= ALU_ADD;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      instret   <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      leds      <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step) begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc[ADDR_WIDTH-1:0];
          end
        end
        S_FETCH: begin
          if (mem_req) begin
            if (mem_ready) begin
              ir      <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_DECODE;
            end
          end else if (!step_mode || step) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc[ADDR_WIDTH-1:0];
          end else begin
            state <= S_IDLE;
          end
        end
        S_DECODE: begin
          a_q      <= rf_rdata1;
          b_q      <= rf_rdata2;
          imm_q    <= imm_d;
          alu_op_q <= alu_op_d;
          if (legal) begin
            state <= S_EXECUTE;
          end else begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= (ir != EBREAK);
          end
        end
        S_EXECUTE: begin
          alu_q <= alu_d;
          if (is_ctrl) begin
            if (target_bad) begin
              state   <= S_HALT;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
          end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
            if (alu_d[1:0] != 2'b00) begin
              state   <= S_HALT;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end else begin
              state     <= S_MEM;
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OPC_STORE);
              mem_addr  <= alu_d[ADDR_WIDTH-1:0];
              mem_wdata <= b_q;
            end
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (opcode == OPC_LOAD) begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB:    ;
        S_HALT:  ;
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase

      // Common retire path; overrides the per-state next-state choice above.
      if (retire_now) begin
        pc      <= next_pc;
        retire  <= 1'b1;
        instret <= instret + 32'd1;
        leds    <= led_fold(retire_val);
        if (step_mode) begin
          state <= S_IDLE;
        end else begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= next_pc[ADDR_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core with a wait-state memory model and hand-computed expectations.
module tb_multi_cycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        retire, halted, illegal;
  logic [31:0] instret;
  logic [7:0]  leds;

  multi_cycle_core #(.ADDR_WIDTH(10), .RESET_PC(32'h0000_0000), .LED_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .step_mode(step_mode), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .instret(instret), .halted(halted), .illegal(illegal), .leds(leds)
  );

  always #5 clk = ~clk;

  logic [31:0]  prog [256];
  logic [31:0]  dmem [256];
  logic [255:0] dvalid = '0;
  logic         clr_dmem = 1'b0;
  int           wait_states = 0;
  int           wcnt = 0;
  logic [31:0]  last_waddr = '0;
  logic [31:0]  last_wdata = '0;
  logic [7:0]   widx;

  assign widx      = mem_addr[9:2];
  assign mem_ready = mem_req && (wcnt == wait_states);
  assign mem_rdata = dvalid[widx] ? dmem[widx] : prog[widx];

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (clr_dmem) begin
      dvalid <= '0;
    end else if (mem_req && mem_we && mem_ready) begin
      dmem[widx]   <= mem_wdata;
      dvalid[widx] <= 1'b1;
      last_waddr   <= {22'b0, mem_addr};
      last_wdata   <= mem_wdata;
    end
  end

  int          cyc = 0;
  int          n_ret = 0;
  int          req_starts = 0;
  logic        req_prev = 1'b0;
  int          ret_cyc [64];
  logic [31:0] ret_pc  [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire && n_ret < 64) begin
      ret_cyc[n_ret] = cyc;
      ret_pc[n_ret]  = dut.pc;
      n_ret = n_ret + 1;
    end
    if (mem_req && !req_prev) req_starts = req_starts + 1;
    req_prev = mem_req;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic start_run(input int ws, input logic sm);
    rst = 1'b0;
    step = 1'b0;
    step_mode = sm;
    wait_states = ws;
    clr_dmem = 1'b1;
    repeat (2) @(negedge clk);
    clr_dmem = 1'b0;
    rst = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic load_add_prog();
    clear_prog();
    prog[0] = 32'h0050_0093;  // addi x1,x0,5
    prog[1] = 32'h0070_0113;  // addi x2,x0,7
    prog[2] = 32'h0020_81B3;  // add  x3,x1,x2
    prog[3] = 32'h0010_0073;  // ebreak
  endtask

  int b, r0;

  initial begin
    // Arithmetic program, zero-wait memory
    load_add_prog();
    start_run(0, 1'b0);
    b = n_ret;
    run_to_halt("t1_halt", 200);
    chk("t1_x3", dut.u_rf.regs[3], 32'd12);
    chk("t1_instret", instret, 32'd3);
    chk("t1_illegal", 32'(illegal), 32'd0);
    chk("t1_leds", 32'(leds), 32'h0C);
    chk("t1_add_latency", 32'(ret_cyc[b+2] - ret_cyc[b+1]), 32'd4);

    // Asynchronous reset clears everything
    rst = 1'b0;
    #1;
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_x3", dut.u_rf.regs[3], 32'd0);

    // Store then load with two wait states per access
    clear_prog();
    prog[0] = 32'h00C0_0193;  // addi x3,x0,12
    prog[1] = 32'h0430_2023;  // sw   x3,0x40(x0)
    prog[2] = 32'h0400_2203;  // lw   x4,0x40(x0)
    prog[3] = 32'h0010_0073;  // ebreak
    start_run(2, 1'b0);
    b = n_ret;
    run_to_halt("t2_halt", 400);
    chk("t2_waddr", last_waddr, 32'h40);
    chk("t2_wdata", last_wdata, 32'd12);
    chk("t2_x4", dut.u_rf.regs[4], 32'd12);
    chk("t2_lw_latency", 32'(ret_cyc[b+2] - ret_cyc[b+1]), 32'd9);
    chk("t2_instret", instret, 32'd3);
    chk("t2_illegal", 32'(illegal), 32'd0);

    // Branches and jal
    clear_prog();
    prog[0] = 32'h0010_8463;  // 0x00 beq x1,x1,+8
    prog[1] = 32'h0010_0313;  // 0x04 addi x6,x0,1 (skipped)
    prog[2] = 32'h0010_9463;  // 0x08 bne x1,x1,+8 (falls through)
    prog[3] = 32'h0002_9463;  // 0x0C bne x5,x0,+8
    prog[4] = 32'hFFDF_F2EF;  // 0x10 jal x5,-4
    prog[5] = 32'h0010_0073;  // 0x14 ebreak
    start_run(0, 1'b0);
    b = n_ret;
    run_to_halt("t3_halt", 300);
    chk("t3_pc_beq", ret_pc[b], 32'h08);
    chk("t3_pc_bne", ret_pc[b+1], 32'h0C);
    chk("t3_pc_bne0", ret_pc[b+2], 32'h10);
    chk("t3_pc_jal", ret_pc[b+3], 32'h0C);
    chk("t3_pc_bne1", ret_pc[b+4], 32'h14);
    chk("t3_x5", dut.u_rf.regs[5], 32'h14);
    chk("t3_x6", dut.u_rf.regs[6], 32'h0);
    chk("t3_instret", instret, 32'd5);
    chk("t3_leds", 32'(leds), 32'h14);
    chk("t3_illegal", 32'(illegal), 32'd0);

    // Illegal opcode
    clear_prog();
    prog[0] = 32'h0000_007F;
    start_run(0, 1'b0);
    run_to_halt("t4_halt", 100);
    chk("t4_illegal", 32'(illegal), 32'd1);
    chk("t4_instret", instret, 32'd0);
    r0 = req_starts;
    repeat (20) @(negedge clk);
    chk("t4_no_req", 32'(req_starts - r0), 32'd0);
    chk("t4_req_low", 32'(mem_req), 32'd0);

    // Misaligned load: only the instruction fetch may reach memory
    clear_prog();
    prog[0] = 32'h0410_2203;  // lw x4,0x41(x0)
    start_run(0, 1'b0);
    r0 = req_starts;
    run_to_halt("t5_halt", 100);
    chk("t5_illegal", 32'(illegal), 32'd1);
    chk("t5_req_count", 32'(req_starts - r0), 32'd1);
    chk("t5_instret", instret, 32'd0);

    // Single-step mode
    load_add_prog();
    start_run(0, 1'b1);
    b = n_ret;
    r0 = req_starts;
    repeat (10) @(negedge clk);
    chk("t6_no_fetch", 32'(req_starts - r0), 32'd0);
    chk("t6_instret0", instret, 32'd0);
    for (int p = 1; p <= 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (10) @(negedge clk);
      chk("t6_instret_step", instret, 32'(p));
      chk("t6_retires_step", 32'(n_ret - b), 32'(p));
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_x3", dut.u_rf.regs[3], 32'd12);
    chk("t6_instret_end", instret, 32'd3);

    // Reset mid-fetch with a slow memory
    load_add_prog();
    start_run(5, 1'b0);
    b = n_ret;
    for (int i = 0; i < 200 && (n_ret - b) < 2; i++) @(negedge clk);
    chk("t7_midfetch_req", 32'(mem_req), 32'd1);
    chk("t7_midfetch_ready", 32'(mem_ready), 32'd0);
    chk("t7_pc_before", dut.pc, 32'h08);
    rst = 1'b0;
    #1;
    chk("t7_req_drop", 32'(mem_req), 32'd0);
    chk("t7_pc_reset", dut.pc, 32'h0);
    chk("t7_instret_reset", instret, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("t7_refetch_req", 32'(mem_req), 32'd1);
    chk("t7_refetch_addr", 32'(mem_addr), 32'h0);
    run_to_halt("t7_halt", 400);
    chk("t7_x3", dut.u_rf.regs[3], 32'd12);
    chk("t7_instret", instret, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
